// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//
// MEM stage of a 5-stage pipeline.
//   * Drives a request/grant/rvalid data-memory port.
//   * Builds byte enables and replicated write data for stores.
//   * Lane-selects and extends load data.
//   * Flags misaligned accesses.
//   * Stalls the upstream stages while an access is still in flight.
//   * Owns the MEM/WB pipeline register.
//
// Ports
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_*_m                 EX/MEM inputs, held stable by upstream while
//                         o_stall_m=1
//   o_dmem_*              request side of the data-memory port
//   i_dmem_*              grant, read-valid and read data from the memory
//   o_stall_m             freezes IF/ID/EX
//   o_misaligned_m        one-cycle flag, raised when a misaligned access
//                         is dropped
//   o_*_w                 registered MEM/WB outputs
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // EX/MEM
  input  logic [DATA_WIDTH-1:0] i_alu_result_m,
  input  logic [DATA_WIDTH-1:0] i_write_data_m,
  input  logic                  i_regwrite_m,
  input  logic                  i_memwrite_m,
  input  logic [1:0]            i_resultsrc_m,
  input  logic [1:0]            i_storetype_m,
  input  logic [2:0]            i_loadtype_m,
  input  logic [4:0]            i_rd_addr_m,
  input  logic [ADDR_WIDTH-1:0] i_pc4_m,
  // data memory
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [3:0]            o_dmem_be,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  input  logic                  i_dmem_gnt,
  input  logic                  i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  // control
  output logic                  o_stall_m,
  output logic                  o_misaligned_m,
  // MEM/WB
  output logic                  o_regwrite_w,
  output logic [1:0]            o_resultsrc_w,
  output logic [DATA_WIDTH-1:0] o_alu_result_w,
  output logic [DATA_WIDTH-1:0] o_read_data_w,
  output logic [4:0]            o_rd_addr_w,
  output logic [ADDR_WIDTH-1:0] o_pc4_w
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_e;

  state_e state_q, state_d;

  logic                  is_store, is_load, access, misaligned;
  logic [1:0]            addr_lo;
  logic                  load_done;
  logic [DATA_WIDTH-1:0] lane_data, load_data;
  logic [3:0]            store_be;

  logic                  misaligned_q, misaligned_d;
  logic                  regwrite_q, regwrite_d;
  logic [1:0]            resultsrc_q, resultsrc_d;
  logic [DATA_WIDTH-1:0] alu_result_q, alu_result_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic [4:0]            rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] pc4_q, pc4_d;

  // A store wins when both memwrite and a load result source are set.
  assign is_store = i_memwrite_m;
  assign is_load  = !i_memwrite_m && (i_resultsrc_m == 2'b01);
  assign access   = is_store || is_load;
  assign addr_lo  = i_alu_result_m[1:0];

  // Reserved store type 11 behaves as a word store.
  always_comb begin
    misaligned = 1'b0;
    if (is_store) begin
      unique case (i_storetype_m)
        2'b01:   misaligned = addr_lo[0];
        2'b10:   misaligned = 1'b0;
        default: misaligned = (addr_lo != 2'b00);
      endcase
    end else if (is_load) begin
      unique case (i_loadtype_m)
        3'b010:         misaligned = (addr_lo != 2'b00);
        3'b001, 3'b101: misaligned = addr_lo[0];
        default:        misaligned = 1'b0;
      endcase
    end
  end

  // Store lane steering.
  always_comb begin
    unique case (i_storetype_m)
      2'b01: begin
        store_be     = 4'b0011 << {addr_lo[1], 1'b0};
        o_dmem_wdata = {(DATA_WIDTH/16){i_write_data_m[15:0]}};
      end
      2'b10: begin
        store_be     = 4'b0001 << addr_lo;
        o_dmem_wdata = {(DATA_WIDTH/8){i_write_data_m[7:0]}};
      end
      default: begin
        store_be     = 4'b1111;
        o_dmem_wdata = i_write_data_m;
      end
    endcase
  end

  // Load lane selection: shift the addressed byte/half down to bit 0.
  assign lane_data = i_dmem_rdata >> {addr_lo, 3'b000};

  always_comb begin
    unique case (i_loadtype_m)
      3'b000:  load_data = {{(DATA_WIDTH-8){lane_data[7]}}, lane_data[7:0]};
      3'b001:  load_data = {{(DATA_WIDTH-16){lane_data[15]}}, lane_data[15:0]};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, lane_data[7:0]};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, lane_data[15:0]};
      default: load_data = i_dmem_rdata;
    endcase
  end

  // Access FSM. gnt and rvalid are only looked at in the states that
  // expect them.
  always_comb begin
    // NOTE: every output of this block gets a default first. Otherwise a path
    // that skips an assignment would infer a latch.
    state_d    = state_q;
    o_dmem_req = 1'b0;
    o_stall_m  = 1'b0;
    load_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access && !misaligned) begin
          o_dmem_req = 1'b1;
          if (!i_dmem_gnt) begin
            state_d   = REQ;
            o_stall_m = 1'b1;
          end else if (is_load) begin
            state_d   = WAIT_R;
            o_stall_m = 1'b1;
          end
        end
      end
      REQ: begin
        o_dmem_req = 1'b1;
        o_stall_m  = 1'b1;
        if (i_dmem_gnt) begin
          if (is_store) begin
            state_d   = IDLE;
            o_stall_m = 1'b0;
          end else begin
            state_d = WAIT_R;
          end
        end
      end
      WAIT_R: begin
        if (i_dmem_rvalid) begin
          state_d   = IDLE;
          load_done = 1'b1;
        end else begin
          o_stall_m = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_dmem_we   = o_dmem_req && i_memwrite_m;
  assign o_dmem_be   = o_dmem_we ? store_be : 4'b0000;
  assign o_dmem_addr = i_alu_result_m[ADDR_WIDTH-1:0];

  // A misaligned access is only recognised in IDLE. Inputs are frozen
  // afterwards, so later states only ever see aligned accesses.
  assign misaligned_d = (state_q == IDLE) && access && misaligned;

  // MEM/WB register.
  always_comb begin
    regwrite_d   = 1'b0;
    resultsrc_d  = resultsrc_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    rd_addr_d    = rd_addr_q;
    pc4_d        = pc4_q;
    if (!o_stall_m) begin
      regwrite_d   = i_regwrite_m && !misaligned_d;
      resultsrc_d  = i_resultsrc_m;
      alu_result_d = i_alu_result_m;
      rd_addr_d    = i_rd_addr_m;
      pc4_d        = i_pc4_m;
      if (load_done) read_data_d = load_data;
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every flop then
    // samples pre-edge values, and there are no ordering races between blocks.
    if (i_rst) begin
      state_q      <= IDLE;
      misaligned_q <= 1'b0;
      regwrite_q   <= 1'b0;
      resultsrc_q  <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      rd_addr_q    <= '0;
      pc4_q        <= '0;
    end else begin
      state_q      <= state_d;
      misaligned_q <= misaligned_d;
      regwrite_q   <= regwrite_d;
      resultsrc_q  <= resultsrc_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      rd_addr_q    <= rd_addr_d;
      pc4_q        <= pc4_d;
    end
  end

  assign o_misaligned_m = misaligned_q;
  assign o_regwrite_w   = regwrite_q;
  assign o_resultsrc_w  = resultsrc_q;
  assign o_alu_result_w = alu_result_q;
  assign o_read_data_w  = read_data_q;
  assign o_rd_addr_w    = rd_addr_q;
  assign o_pc4_w        = pc4_q;

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
//
// Directed bench for memory_stage.
// Inputs change on the falling edge. Combinational outputs are checked 1 ns
// later. Registered outputs are checked 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_m, write_data_m;
  logic        regwrite_m, memwrite_m;
  logic [1:0]  resultsrc_m, storetype_m;
  logic [2:0]  loadtype_m;
  logic [4:0]  rd_addr_m;
  logic [9:0]  pc4_m;
  logic        dmem_req, dmem_we;
  logic [9:0]  dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        stall_m, misaligned_m;
  logic        regwrite_w;
  logic [1:0]  resultsrc_w;
  logic [31:0] alu_result_w, read_data_w;
  logic [4:0]  rd_addr_w;
  logic [9:0]  pc4_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_result_m(alu_result_m), .i_write_data_m(write_data_m),
    .i_regwrite_m(regwrite_m), .i_memwrite_m(memwrite_m),
    .i_resultsrc_m(resultsrc_m), .i_storetype_m(storetype_m),
    .i_loadtype_m(loadtype_m), .i_rd_addr_m(rd_addr_m), .i_pc4_m(pc4_m),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_be(dmem_be), .o_dmem_wdata(dmem_wdata),
    .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_stall_m(stall_m), .o_misaligned_m(misaligned_m),
    .o_regwrite_w(regwrite_w), .o_resultsrc_w(resultsrc_w),
    .o_alu_result_w(alu_result_w), .o_read_data_w(read_data_w),
    .o_rd_addr_w(rd_addr_w), .o_pc4_w(pc4_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    alu_result_m = '0; write_data_m = '0; regwrite_m = 1'b0; memwrite_m = 1'b0;
    resultsrc_m  = '0; storetype_m  = '0; loadtype_m = '0;  rd_addr_m  = '0;
    pc4_m        = '0; dmem_gnt     = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
  endtask

  task automatic after_rise();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    after_rise();
    after_rise();
    check("rst_regwrite_w",   regwrite_w,   0);
    check("rst_read_data_w",  read_data_w,  0);
    check("rst_alu_result_w", alu_result_w, 0);
    check("rst_pc4_w",        pc4_w,        0);
    check("rst_misaligned",   misaligned_m, 0);
    check("rst_stall",        stall_m,      0);
    check("rst_req",          dmem_req,     0);

    // SB to 0x006, granted in the same cycle.
    @(negedge clk);
    rst = 1'b0;
    memwrite_m = 1'b1; storetype_m = 2'b10; alu_result_m = 32'h006;
    write_data_m = 32'h0000_00A5; pc4_m = 10'h010; dmem_gnt = 1'b1;
    #1;
    check("sb_req",   dmem_req,   1);
    check("sb_we",    dmem_we,    1);
    check("sb_addr",  dmem_addr,  32'h006);
    check("sb_be",    dmem_be,    4'b0100);
    check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    check("sb_stall", stall_m,    0);
    after_rise();
    check("sb_alu_w", alu_result_w, 32'h006);
    check("sb_pc4_w", pc4_w,        10'h010);
    check("sb_rw_w",  regwrite_w,   0);

    // SH to 0x002, also granted at once.
    @(negedge clk);
    storetype_m = 2'b01; alu_result_m = 32'h002; write_data_m = 32'hFFFF_1234;
    #1;
    check("sh_be",    dmem_be,    4'b1100);
    check("sh_wdata", dmem_wdata, 32'h1234_1234);
    check("sh_stall", stall_m,    0);

    // LB from 0x003: grant after two cycles, rvalid one cycle after that.
    @(negedge clk);
    clear_inputs();
    resultsrc_m = 2'b01; loadtype_m = 3'b000; alu_result_m = 32'h003;
    regwrite_m = 1'b1; rd_addr_m = 5'd5; pc4_m = 10'h020;
    #1;
    check("lb_c0_req",   dmem_req, 1);
    check("lb_c0_we",    dmem_we,  0);
    check("lb_c0_stall", stall_m,  1);
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;   // unexpected, must be ignored
    #1;
    check("lb_c1_req",    dmem_req,   1);
    check("lb_c1_stall",  stall_m,    1);
    check("lb_c1_bubble", regwrite_w, 0);
    @(negedge clk);
    dmem_rvalid = 1'b0; dmem_gnt = 1'b1;
    #1;
    check("lb_c2_req",   dmem_req, 1);
    check("lb_c2_stall", stall_m,  1);
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_1234;
    #1;
    check("lb_c3_req",   dmem_req, 0);
    check("lb_c3_stall", stall_m,  0);
    after_rise();
    check("lb_data_w", read_data_w, 32'hFFFF_FF80);
    check("lb_rw_w",   regwrite_w,  1);
    check("lb_rd_w",   rd_addr_w,   5);
    check("lb_src_w",  resultsrc_w, 2'b01);
    check("lb_pc4_w",  pc4_w,       10'h020);

    // LHU from 0x002, granted in IDLE.
    @(negedge clk);
    clear_inputs();
    resultsrc_m = 2'b01; loadtype_m = 3'b101; alu_result_m = 32'h002;
    regwrite_m = 1'b1; rd_addr_m = 5'd6; dmem_gnt = 1'b1;
    #1;
    check("lhu_stall", stall_m, 1);
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_0000;
    after_rise();
    check("lhu_data_w", read_data_w, 32'h0000_BEEF);
    check("lhu_rd_w",   rd_addr_w,   6);

    // LH from 0x000 with a negative half-word.
    @(negedge clk);
    clear_inputs();
    resultsrc_m = 2'b01; loadtype_m = 3'b001; alu_result_m = 32'h000;
    regwrite_m = 1'b1; rd_addr_m = 5'd9; dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000_8001;
    after_rise();
    check("lh_data_w", read_data_w, 32'hFFFF_8001);

    // Misaligned SW to 0x001: dropped, flagged for one cycle, no writeback.
    @(negedge clk);
    clear_inputs();
    memwrite_m = 1'b1; storetype_m = 2'b00; alu_result_m = 32'h001;
    regwrite_m = 1'b1; dmem_gnt = 1'b1;
    #1;
    check("sw_mis_req",   dmem_req, 0);
    check("sw_mis_stall", stall_m,  0);
    after_rise();
    check("sw_mis_flag", misaligned_m, 1);
    check("sw_mis_rw_w", regwrite_w,   0);

    // Non-access instruction: one-cycle pass-through, and the flag drops.
    @(negedge clk);
    clear_inputs();
    regwrite_m = 1'b1; rd_addr_m = 5'd7; alu_result_m = 32'h0000_1234; pc4_m = 10'h044;
    #1;
    check("alu_req",   dmem_req, 0);
    check("alu_stall", stall_m,  0);
    after_rise();
    check("alu_flag_clr", misaligned_m, 0);
    check("alu_rw_w",     regwrite_w,   1);
    check("alu_rd_w",     rd_addr_w,    7);
    check("alu_res_w",    alu_result_w, 32'h0000_1234);
    check("alu_keep_rd",  read_data_w,  32'hFFFF_8001);

    // LW granted, then reset in WAIT_R, then a late rvalid.
    @(negedge clk);
    clear_inputs();
    resultsrc_m = 2'b01; loadtype_m = 3'b010; alu_result_m = 32'h008;
    regwrite_m = 1'b1; rd_addr_m = 5'd3; dmem_gnt = 1'b1;
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rstw_req",   dmem_req, 0);
    check("rstw_stall", stall_m,  0);
    check("rstw_rw_w",  regwrite_w, 0);
    after_rise();
    check("rstw_data_w", read_data_w, 0);
    check("rstw_rw_w2",  regwrite_w,  0);
    check("rstw_rd_w",   rd_addr_w,   0);
    check("rstw_pc4_w",  pc4_w,       0);
    check("rstw_flag",   misaligned_m, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
